mem_buffer: RTL and testbench

Memory-side buffer between the controller and the external memory bus; this stage produces the Read_Data consumed by the temp register.
- Takes single read/write commands from the controller.
- Runs a req/ack handshake on the memory bus.
- Captures returned read data into a holding register and signals completion with a one-cycle Mem_Done.
- The controller uses Mem_Done to raise Load_Temp.

---
 rtl/mem_buffer_pkg.sv | 19 +
 rtl/mem_buffer_if.sv | 36 +++
 rtl/mem_wait_cnt.sv | 30 +++
 rtl/mem_buffer.sv | 102 ++++++++++
 tb/tb_mem_buffer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mem_buffer_pkg.sv
// rtl/mem_buffer_pkg.sv - shared types and defaults for the memory-side buffer
package mem_buffer_pkg;

  localparam int ADDR_W_DEF      = 12;
  localparam int DATA_W_DEF      = 16;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wait counter only needs to reach limit-1; keep at least one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/mem_buffer_if.sv
// rtl/mem_buffer_if.sv - controller command and memory bus signals of the buffer
interface mem_buffer_if import mem_buffer_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              Mem_Read;
  logic              Mem_Write;
  logic [ADDR_W-1:0] Addr_In;
  logic [DATA_W-1:0] Write_Data;
  logic [DATA_W-1:0] Read_Data;
  logic              Mem_Done;
  logic              Mem_Busy;
  logic              Bus_Req;
  logic              Bus_We;
  logic [ADDR_W-1:0] Bus_Addr;
  logic [DATA_W-1:0] Bus_Wdata;
  logic [DATA_W-1:0] Bus_Rdata;
  logic              Bus_Ack;
  logic              Bus_Err;

  // The buffer itself.
  modport slave (
    input  Mem_Read, Mem_Write, Addr_In, Write_Data, Bus_Rdata, Bus_Ack,
    output Read_Data, Mem_Done, Mem_Busy, Bus_Req, Bus_We, Bus_Addr,
           Bus_Wdata, Bus_Err
  );

  // Controller plus memory side driving the buffer.
  modport master (
    output Mem_Read, Mem_Write, Addr_In, Write_Data, Bus_Rdata, Bus_Ack,
    input  Read_Data, Mem_Done, Mem_Busy, Bus_Req, Bus_We, Bus_Addr,
           Bus_Wdata, Bus_Err
  );

endinterface

// File: rtl/mem_wait_cnt.sv
// rtl/mem_wait_cnt.sv - clearable up-counter with terminal flag for bus-ack timeout
module mem_wait_cnt import mem_buffer_pkg::*; #(
  parameter int LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int W = cnt_width(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

  // hit on the LIMIT-th waiting edge after a clear
  assign hit = (cnt == LAST);

endmodule

// File: rtl/mem_buffer.sv
// rtl/mem_buffer.sv - single-command req/ack memory buffer; MEM_TIMEOUT_EN enables ack timeout abort
module mem_buffer import mem_buffer_pkg::*; #(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic         Clk,
  input  logic         Rst,
  mem_buffer_if.slave  mem
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_buffer: TIMEOUT_CYC must be at least 1");
  end

  state_t            state;
  logic [DATA_W-1:0] read_data_q;
  logic              mem_done_q;
  logic              mem_busy_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic              bus_err_q;
  logic              timeout_hit;

`ifdef MEM_TIMEOUT_EN
  mem_wait_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wait_cnt (
    .Clk (Clk),
    .Rst (Rst),
    .clr (state != REQ),
    .en  ((state == REQ) && !mem.Bus_Ack),
    .hit (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= IDLE;
      read_data_q <= '0;
      mem_done_q  <= 1'b0;
      mem_busy_q  <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      mem_done_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (mem.Mem_Read || mem.Mem_Write) begin
            bus_addr_q  <= mem.Addr_In;
            bus_wdata_q <= mem.Write_Data;
            // read wins when both are requested; the write is simply dropped
            bus_we_q    <= mem.Mem_Write & ~mem.Mem_Read;
            bus_req_q   <= 1'b1;
            mem_busy_q  <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (mem.Bus_Ack) begin
            bus_req_q  <= 1'b0;
            mem_done_q <= 1'b1;
            if (!bus_we_q) begin
              read_data_q <= mem.Bus_Rdata;
            end
            state <= DONE;
          end else if (timeout_hit) begin
            bus_req_q  <= 1'b0;
            mem_done_q <= 1'b1;
            bus_err_q  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          mem_busy_q <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem.Read_Data = read_data_q;
  assign mem.Mem_Done  = mem_done_q;
  assign mem.Mem_Busy  = mem_busy_q;
  assign mem.Bus_Req   = bus_req_q;
  assign mem.Bus_We    = bus_we_q;
  assign mem.Bus_Addr  = bus_addr_q;
  assign mem.Bus_Wdata = bus_wdata_q;
  assign mem.Bus_Err   = bus_err_q;

endmodule

// File: tb/tb_mem_buffer.sv
// tb/tb_mem_buffer.sv - directed scoreboard bench for mem_buffer (timeout step under MEM_TIMEOUT_EN)
module tb_mem_buffer;
  import mem_buffer_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int TO = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  mem_buffer_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  mem_buffer #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .mem (mif)
  );

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  int            req_rises = 0;
  logic [DW-1:0] model_rd = '0;

  always @(posedge mif.Bus_Req) req_rises++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One command with ack after 'delay' REQ cycles; 'noise' re-pulses Mem_Read in REQ and DONE.
  task automatic run_txn(input logic rd, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                         input int delay, input bit noise);
    exp_t e;
    exp_t got;
    int   rises0;
    e.we    = wr & ~rd;
    e.addr  = addr;
    e.wdata = wdata;
    e.err   = 1'b0;
    if (rd) model_rd = rdata;
    e.rdata = model_rd;
    sb.push_back(e);
    rises0 = req_rises;

    mif.Mem_Read   = rd;
    mif.Mem_Write  = wr;
    mif.Addr_In    = addr;
    mif.Write_Data = wdata;
    @(negedge Clk);
    mif.Mem_Read   = noise;
    mif.Mem_Write  = 1'b0;
    mif.Addr_In    = ~addr;
    mif.Write_Data = ~wdata;
    check("busy_in_req", 32'(mif.Mem_Busy), 32'd1);
    for (int i = 0; i <= delay; i++) begin
      check("req_held",   32'(mif.Bus_Req),   32'd1);
      check("we_held",    32'(mif.Bus_We),    32'(e.we));
      check("addr_held",  32'(mif.Bus_Addr),  32'(e.addr));
      check("wdata_held", 32'(mif.Bus_Wdata), 32'(e.wdata));
      check("done_early", 32'(mif.Mem_Done),  32'd0);
      if (i < delay) @(negedge Clk);
    end
    mif.Bus_Ack   = 1'b1;
    mif.Bus_Rdata = rdata;
    @(negedge Clk);
    mif.Bus_Ack   = 1'b0;
    mif.Bus_Rdata = '0;
    got = sb.pop_front();
    check("done_pulse",  32'(mif.Mem_Done),  32'd1);
    check("req_dropped", 32'(mif.Bus_Req),   32'd0);
    check("err_on_ack",  32'(mif.Bus_Err),   32'(got.err));
    check("read_data",   32'(mif.Read_Data), 32'(got.rdata));
    check("busy_done",   32'(mif.Mem_Busy),  32'd1);
    mif.Mem_Read = noise;
    mif.Addr_In  = 12'hFFF;
    @(negedge Clk);
    mif.Mem_Read = 1'b0;
    check("done_cleared", 32'(mif.Mem_Done),  32'd0);
    check("busy_cleared", 32'(mif.Mem_Busy),  32'd0);
    check("rd_stable",    32'(mif.Read_Data), 32'(got.rdata));
    @(negedge Clk);
    check("idle_no_req",  32'(mif.Bus_Req),   32'd0);
    check("one_req_rise", 32'(req_rises - rises0), 32'd1);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic run_timeout(input logic [AW-1:0] addr);
    exp_t e;
    exp_t got;
    e.we    = 1'b0;
    e.addr  = addr;
    e.wdata = '0;
    e.rdata = model_rd;
    e.err   = 1'b1;
    sb.push_back(e);
    mif.Mem_Read   = 1'b1;
    mif.Addr_In    = addr;
    mif.Write_Data = '0;
    @(negedge Clk);
    mif.Mem_Read = 1'b0;
    for (int i = 0; i < TO; i++) begin
      check("to_req_held", 32'(mif.Bus_Req),  32'd1);
      check("to_no_done",  32'(mif.Mem_Done), 32'd0);
      @(negedge Clk);
    end
    got = sb.pop_front();
    check("to_req_drop", 32'(mif.Bus_Req),   32'd0);
    check("to_done",     32'(mif.Mem_Done),  32'd1);
    check("to_err",      32'(mif.Bus_Err),   32'(got.err));
    check("to_rd_keep",  32'(mif.Read_Data), 32'(got.rdata));
    @(negedge Clk);
    check("to_err_clr",  32'(mif.Bus_Err),   32'd0);
    check("to_done_clr", 32'(mif.Mem_Done),  32'd0);
    check("to_busy_clr", 32'(mif.Mem_Busy),  32'd0);
  endtask
`endif

  initial begin
    mif.Mem_Read   = 1'b0;
    mif.Mem_Write  = 1'b0;
    mif.Addr_In    = '0;
    mif.Write_Data = '0;
    mif.Bus_Rdata  = '0;
    mif.Bus_Ack    = 1'b0;

    #3;
    check("rst_req",   32'(mif.Bus_Req),   32'd0);
    check("rst_busy",  32'(mif.Mem_Busy),  32'd0);
    check("rst_done",  32'(mif.Mem_Done),  32'd0);
    check("rst_rdata", 32'(mif.Read_Data), 32'd0);
    check("rst_addr",  32'(mif.Bus_Addr),  32'd0);
    check("rst_err",   32'(mif.Bus_Err),   32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    run_txn(1'b1, 1'b0, 12'h123, 16'h0000, 16'hBEEF, 3, 1'b0);
    run_txn(1'b0, 1'b1, 12'h0A5, 16'h1234, 16'hDEAD, 2, 1'b0);
    run_txn(1'b1, 1'b1, 12'h010, 16'h5555, 16'hA5A5, 1, 1'b0);
    run_txn(1'b1, 1'b0, 12'h3C3, 16'h0000, 16'h0F0F, 0, 1'b0);
    run_txn(1'b1, 1'b0, 12'h777, 16'h0000, 16'h1357, 2, 1'b1);

    // Ack while idle must not touch Read_Data or complete anything.
    mif.Bus_Ack   = 1'b1;
    mif.Bus_Rdata = 16'hFACE;
    @(negedge Clk);
    mif.Bus_Ack   = 1'b0;
    check("idle_ack_rd",   32'(mif.Read_Data), 32'(model_rd));
    check("idle_ack_done", 32'(mif.Mem_Done),  32'd0);

    // Reset in the middle of REQ.
    mif.Mem_Read = 1'b1;
    mif.Addr_In  = 12'h055;
    @(negedge Clk);
    mif.Mem_Read = 1'b0;
    check("pre_rst_req", 32'(mif.Bus_Req), 32'd1);
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("async_req",   32'(mif.Bus_Req),   32'd0);
    check("async_rdata", 32'(mif.Read_Data), 32'd0);
    check("async_busy",  32'(mif.Mem_Busy),  32'd0);
    model_rd = '0;
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check("post_rst_idle", 32'(mif.Bus_Req), 32'd0);
    run_txn(1'b1, 1'b0, 12'h456, 16'h0000, 16'hC0DE, 1, 1'b0);

`ifdef MEM_TIMEOUT_EN
    run_timeout(12'h2AA);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
